alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Two-port round-robin arbiter and sequencer that time-shares the team's single combinational 4-bit ALU (2-bit op select S, operands A/B, result C, carry Cout) between two requesters. It sits between the requesters and the ALU instance. It latches the winning request's op and operands into the ALU-driving registers, captures C/Cout one cycle later, and returns the result with a one-cycle acknowledge to the granted port. It also keeps per-port completed-operation counters.

## Interface
- WIDTH, 4, operand/result width; must match the ALU
- CNT_W, 8, width of per-port completed-op counters
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0, req1  in  1  level request from port 0 / port 1
- op0, op1  in  2  ALU op select from port 0 / port 1
- a0, b0, a1, b1  in  WIDTH  operands from port 0 / port 1
- ack0, ack1  out  1  one-cycle pulse; result valid for that port
- res  out  WIDTH  captured ALU result; valid while ackN high, held afterwards
- cout  out  1  captured ALU Cout; valid while ackN high, held afterwards
- busy  out  1  high in EXEC and RESP
- cnt0, cnt1  out  CNT_W  completed ops per port; wraps modulo 2^CNT_W
- alu_s  out  2  to ALU S
- alu_a, alu_b  out  WIDTH  to ALU A, B
- alu_c  in  WIDTH  from ALU C
- alu_cout  in  1  from ALU Cout

## Operation
- Op encoding, passed through unmodified: 00 add, 01 sub, 10 and, 11 or. Carry semantics are the ALU's; the controller only registers alu_cout.
- States:
  - IDLE: sample req0/req1. If either is high, choose a winner, go to EXEC. Otherwise stay.
  - EXEC: alu_s/alu_a/alu_b registers hold the granted port's op/a/b. Go to RESP.
  - RESP: res/cout hold the values captured at the EXEC→RESP edge; ackN is high for the granted port only; cntN increments. Go to IDLE.
- Arbitration:
  - Only one requester → it wins.
  - Both → the port not granted last wins.
  - Register last_grant resets to 1, so port 0 wins the first tie.
- Operands and op are sampled only on the IDLE→EXEC edge. Later changes on the requester's inputs are ignored.
- Requester protocol:
  - Hold req until ack.
  - Dropping req before it is sampled in IDLE withdraws the request, with no side effect.
  - req still high in the IDLE cycle after ack counts as a new request.
- req is ignored in EXEC and RESP. No request is queued.

## Timing
- The request is sampled at edge E (state IDLE). alu_* are updated at E. res/cout are captured and ackN rises at E+1. ackN falls and the state returns to IDLE at E+2.
  - Latency from sampling edge to ack = 2 cycles.
  - Peak throughput = 1 op per 3 cycles.
- With both ports requesting continuously, grants alternate 0,1,0,1…
- No starvation: a waiting port is served within 2 operations.
- Reset values:
  - state IDLE; ack0/ack1 0; busy 0
  - res 0; cout 0; cnt0/cnt1 0
  - alu_s 00; alu_a 0; alu_b 0; last_grant 1
- Reset asserted mid-operation (EXEC or RESP): everything returns to reset values immediately. No ack is issued, the counter is not incremented, and the in-flight op is dropped.
- cntN at 2^CNT_W−1 increments to 0. No flag is raised.
- busy is registered; it equals (state != IDLE).

## Structure
- Package/header alu_share_pkg:
  - op localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11
  - state encoding S_IDLE, S_EXEC, S_RESP (2 bits)
- Sub-module rr_arb2:
  - inputs: req0, req1, last_grant
  - outputs: grant_valid, grant_sel
  - purely combinational
  - the parent owns the last_grant register and updates it on the IDLE→EXEC edge
- The ALU itself stays outside; the bench instantiates the existing ALU and wires it to alu_*.

## Test plan
- Single add:
  - Stimulus: after reset, req0=1, op0=00, a0=1001, b0=0001.
  - Response: alu_s=00, alu_a=1001, alu_b=0001 during EXEC; ack0 2 cycles after sampling; res=1010, cout=0; cnt0=1; ack1 stays 0.
- Overflow add:
  - Stimulus: req1, op1=00, a1=1111, b1=0001.
  - Response: res=0000, cout=1, ack1 pulse one cycle wide; cnt1=1.
- Simultaneous requests after reset:
  - Stimulus: port0 op 10 (1001, 0001); port1 op 11 (1001, 0001); both held.
  - Response: ack0 first with res=0001, then ack1 3 cycles later with res=1001.
- Continuous contention:
  - Stimulus: both req held for 12 ops.
  - Response: strict alternation; cnt0=cnt1=6; busy low exactly one cycle between ops.
- Reset in EXEC:
  - Stimulus: port0 op 01 (1001, 0001); rst pulsed during EXEC.
  - Response: no ack; res=0, cnt0=0, alu_* = 0. The next request completes normally with res=1000.
- Counter wrap (CNT_W=2):
  - Stimulus: 5 port0 ops.
  - Response: cnt0 sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_share_pkg.sv
// Shared constants for the ALU time-sharing controller: ALU op codes and
// sequencer state encoding.
package alu_share_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick; the caller owns and updates last_grant.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_sel
);

    always_comb begin
        grant_valid = req0 | req1;
        // On a tie the port that did not win last time goes next
        if (req0 && req1) begin
            grant_sel = ~last_grant;
        end else begin
            grant_sel = req1;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one external combinational ALU between two requesters:
// grant in IDLE, drive the ALU in EXEC, return result with a one-cycle ack in RESP.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [1:0]       alu_s,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_cout
);

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             sel_q, sel_d;
    logic [1:0]       alu_s_q, alu_s_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic             grant_valid;
    logic             grant_sel;

    rr_arb2 u_arb (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        alu_s_d      = alu_s_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        res_d        = res_q;
        cout_d       = cout_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;

        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    state_d      = S_EXEC;
                    sel_d        = grant_sel;
                    last_grant_d = grant_sel;
                    alu_s_d      = grant_sel ? op1 : op0;
                    alu_a_d      = grant_sel ? a1  : a0;
                    alu_b_d      = grant_sel ? b1  : b0;
                end
            end
            S_EXEC: begin
                state_d = S_RESP;
                res_d   = alu_c;
                cout_d  = alu_cout;
                if (sel_q) begin
                    ack1_d = 1'b1;
                    cnt1_d = cnt1_q + CNT_W'(1);
                end else begin
                    ack0_d = 1'b1;
                    cnt0_d = cnt0_q + CNT_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            sel_q        <= 1'b0;
            alu_s_q      <= 2'b00;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            res_q        <= '0;
            cout_q       <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            alu_s_q      <= alu_s_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            res_q        <= res_d;
            cout_q       <= cout_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign ack0  = ack0_q;
    assign ack1  = ack1_q;
    assign res   = res_q;
    assign cout  = cout_q;
    assign busy  = busy_q;
    assign cnt0  = cnt0_q;
    assign cnt1  = cnt1_q;
    assign alu_s = alu_s_q;
    assign alu_a = alu_a_q;
    assign alu_b = alu_b_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level model of the shared-ALU service.
module tb_alu_share_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0 = 1'b0, req1 = 1'b0;
    logic [1:0]       op0 = '0, op1 = '0;
    logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic             ack0, ack1, cout, busy, alu_cout;
    logic [WIDTH-1:0] res, alu_a, alu_b, alu_c;
    logic [CNT_W-1:0] cnt0, cnt1;
    logic [1:0]       alu_s;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: age 0 = free, 1 = operation in flight, 2 = result being returned
    int               m_age  = 0;
    int               m_port = 0;
    int               m_last = 1;
    int               m_cnt[2] = '{0, 0};
    logic [1:0]       m_s    = '0;
    logic [WIDTH-1:0] m_a    = '0, m_b = '0, m_res = '0;
    logic             m_cout = 1'b0;

    always #5 clk = ~clk;

    alu_share_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .op0      (op0),
        .op1      (op1),
        .a0       (a0),
        .b0       (b0),
        .a1       (a1),
        .b1       (b1),
        .ack0     (ack0),
        .ack1     (ack1),
        .res      (res),
        .cout     (cout),
        .busy     (busy),
        .cnt0     (cnt0),
        .cnt1     (cnt1),
        .alu_s    (alu_s),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_c    (alu_c),
        .alu_cout (alu_cout)
    );

    // Stand-in for the team ALU: sub is a + ~b + 1, logic ops give carry 0
    function automatic logic [WIDTH:0] alu_fn(input logic [1:0] s, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        case (s)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} + {1'b0, ~b} + 1;
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    assign {alu_cout, alu_c} = alu_fn(alu_s, alu_a, alu_b);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    task automatic model_reset();
        m_age = 0; m_port = 0; m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0;
        m_s = '0; m_a = '0; m_b = '0; m_res = '0; m_cout = 1'b0;
    endtask

    task automatic model_edge();
        logic [WIDTH:0] r;
        if (m_age == 2) begin
            m_age = 0;
        end else if (m_age == 1) begin
            r = alu_fn(m_s, m_a, m_b);
            m_res = r[WIDTH-1:0];
            m_cout = r[WIDTH];
            m_cnt[m_port] = (m_cnt[m_port] + 1) % (1 << CNT_W);
            m_age = 2;
        end else if (req0 || req1) begin
            if (req0 && req1) m_port = 1 - m_last;
            else m_port = req1 ? 1 : 0;
            m_last = m_port;
            m_s = m_port ? op1 : op0;
            m_a = m_port ? a1 : a0;
            m_b = m_port ? b1 : b0;
            m_age = 1;
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".ack0"},  ack0,  (m_age == 2 && m_port == 0));
        check_eq({tag, ".ack1"},  ack1,  (m_age == 2 && m_port == 1));
        check_eq({tag, ".busy"},  busy,  (m_age != 0));
        check_eq({tag, ".res"},   res,   m_res);
        check_eq({tag, ".cout"},  cout,  m_cout);
        check_eq({tag, ".cnt0"},  cnt0,  m_cnt[0]);
        check_eq({tag, ".cnt1"},  cnt1,  m_cnt[1]);
        check_eq({tag, ".alu_s"}, alu_s, m_s);
        check_eq({tag, ".alu_a"}, alu_a, m_a);
        check_eq({tag, ".alu_b"}, alu_b, m_b);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check_all(tag);
    endtask

    // Asynchronous reset pulse landing between clock edges
    task automatic pulse_reset(input string tag);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1 rst = 1'b0;
    endtask

    initial begin
        int exp_wrap[5];
        int seen0, seen1;
        exp_wrap = '{1, 2, 3, 0, 1};

        #12;
        model_reset();
        check_all("reset");
        #1 rst = 1'b0;

        // Single add on port 0
        req0 = 1; op0 = 2'b00; a0 = 4'b1001; b0 = 4'b0001;
        step("add_e");
        check_eq("add_alu_a", alu_a, 4'b1001);
        step("add_ack");
        check_eq("add_ack0", ack0, 1'b1);
        check_eq("add_res", res, 4'b1010);
        check_eq("add_cnt0", cnt0, 1);
        req0 = 0;
        step("add_done");

        // Overflow add on port 1
        req1 = 1; op1 = 2'b00; a1 = 4'b1111; b1 = 4'b0001;
        step("ovf_e");
        step("ovf_ack");
        check_eq("ovf_res", res, 4'b0000);
        check_eq("ovf_cout", cout, 1'b1);
        check_eq("ovf_cnt1", cnt1, 1);
        req1 = 0;
        step("ovf_done");
        check_eq("ovf_ack1_width", ack1, 1'b0);

        // Simultaneous requests straight after reset
        pulse_reset("rst_sim");
        req0 = 1; op0 = 2'b10; a0 = 4'b1001; b0 = 4'b0001;
        req1 = 1; op1 = 2'b11; a1 = 4'b1001; b1 = 4'b0001;
        step("sim");
        step("sim");
        check_eq("sim_ack0", ack0, 1'b1);
        check_eq("sim_res0", res, 4'b0001);
        req0 = 0;
        step("sim");
        step("sim");
        step("sim");
        check_eq("sim_ack1", ack1, 1'b1);
        check_eq("sim_res1", res, 4'b1001);
        req1 = 0;
        step("sim");

        // Continuous contention for 12 operations
        seen0 = 0; seen1 = 0;
        req0 = 1; req1 = 1;
        for (int i = 0; i < 36; i++) begin
            step("cont");
            seen0 += int'(ack0);
            seen1 += int'(ack1);
        end
        req0 = 0; req1 = 0;
        check_eq("cont_acks0", seen0, 6);
        check_eq("cont_acks1", seen1, 6);
        step("cont_end");

        // Reset while in EXEC drops the operation
        req0 = 1; op0 = 2'b01; a0 = 4'b1001; b0 = 4'b0001;
        step("rexec_e");
        pulse_reset("rexec_rst");
        check_eq("rexec_res", res, 0);
        check_eq("rexec_cnt0", cnt0, 0);
        check_eq("rexec_alu_a", alu_a, 0);
        step("rexec_re");
        step("rexec_ack");
        check_eq("rexec_ack0", ack0, 1'b1);
        check_eq("rexec_res2", res, 4'b1000);
        req0 = 0;
        step("rexec_done");

        // Counter wrap with a 2-bit counter
        pulse_reset("rst_wrap");
        req0 = 1;
        for (int k = 0; k < 5; k++) begin
            step("wrap");
            step("wrap");
            check_eq("wrap_cnt0", cnt0, exp_wrap[k]);
            step("wrap");
        end
        req0 = 0;
        step("wrap_end");

        // Randomized traffic, operands churn every cycle, occasional resets
        for (int i = 0; i < 600; i++) begin
            req0 = ($urandom_range(0, 2) != 0);
            req1 = ($urandom_range(0, 2) != 0);
            op0 = 2'($urandom); op1 = 2'($urandom);
            a0 = 4'($urandom); b0 = 4'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom);
            step("rand");
            if ($urandom_range(0, 79) == 0) pulse_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
